rf_bypass_param: RTL and testbench



---
 rtl/rf_bypass_param.sv | 104 ++++++++++
 tb/tb_rf_bypass_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rf_bypass_param.sv
// rf_bypass_param: NREGS x WIDTH register file with one write port and two
// combinational read ports. Optional same-cycle write-to-read bypass and an
// optional hardwired-zero register 0. Out-of-range selects raise err, which
// accumulates into errSticky until cleared.
module rf_bypass_param #(
   parameter int WIDTH   = 16,
   parameter int NREGS   = 8,
   parameter int SEL_W   = $clog2(NREGS),
   parameter int BYPASS  = 1,
   parameter int ZERO_R0 = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SEL_W-1:0] readReg1Sel,
   input  logic [SEL_W-1:0] readReg2Sel,
   input  logic [SEL_W-1:0] writeRegSel,
   input  logic [WIDTH-1:0] writeData,
   input  logic             writeEn,
   input  logic             errClr,
   output logic [WIDTH-1:0] readData1,
   output logic [WIDTH-1:0] readData2,
   output logic             err,
   output logic             errSticky
);

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic [NREGS-1:0] wr_hit;
   logic             err_sticky_q, err_sticky_d;
   logic             wr_in_range, rd1_in_range, rd2_in_range;
   logic [WIDTH-1:0] rd1, rd2;

   // Per-register write-enable decode. Gating with rst_n keeps both storage
   // and the bypass path quiet while the block is held in reset. A
   // hardwired-zero register 0 never sees a write strobe.
   for (genvar i = 0; i < NREGS; i++) begin : g_wdec
      if (ZERO_R0 != 0 && i == 0) begin : g_r0
         assign wr_hit[i] = 1'b0;
      end else begin : g_rn
         assign wr_hit[i] = rst_n & writeEn & (writeRegSel == SEL_W'(i));
      end
   end

   // Range checks only exist when the select space has unused codes.
   if (NREGS == (1 << SEL_W)) begin : g_pow2
      assign wr_in_range  = 1'b1;
      assign rd1_in_range = 1'b1;
      assign rd2_in_range = 1'b1;
   end else begin : g_npow2
      assign wr_in_range  = (writeRegSel < SEL_W'(NREGS));
      assign rd1_in_range = (readReg1Sel < SEL_W'(NREGS));
      assign rd2_in_range = (readReg2Sel < SEL_W'(NREGS));
   end

   assign err = (writeEn & ~wr_in_range) | ~rd1_in_range | ~rd2_in_range;

   // Next-state for storage and the sticky error flag.
   always_comb begin
      // NOTE: every signal assigned here gets a value on every path; a missed
      // branch would otherwise infer a latch.
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = wr_hit[i] ? writeData : regs_q[i];
      end
      // Set wins over clear when both happen in the same cycle.
      err_sticky_d = (err_sticky_q & ~errClr) | err;
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the storage array is reset deliberately; software relies on
         // every register reading zero after reset, so this is not left to X.
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         err_sticky_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         regs_q       <= regs_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   // Parametrised read mux; unmatched (out-of-range) selects fall through to 0.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (!(ZERO_R0 != 0 && i == 0)) begin
            if (readReg1Sel == SEL_W'(i)) begin
               rd1 = (BYPASS != 0 && wr_hit[i]) ? writeData : regs_q[i];
            end
            if (readReg2Sel == SEL_W'(i)) begin
               rd2 = (BYPASS != 0 && wr_hit[i]) ? writeData : regs_q[i];
            end
         end
      end
   end

   assign readData1 = rd1;
   assign readData2 = rd2;
   assign errSticky = err_sticky_q;

endmodule

// File: tb/tb_rf_bypass_param.sv
// Directed bench for rf_bypass_param. Four configurations share clock, reset
// and selects; each has its own write enable so only the instance under test
// changes state.
module tb_rf_bypass_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  sel1, sel2, wsel;
   logic [31:0] wd;
   logic        we_a, we_b, we_c, we_d, err_clr;

   logic [15:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_d, rd2_d;
   logic [31:0] rd1_c, rd2_c;
   logic        err_a, err_b, err_c, err_d;
   logic        sticky_a, sticky_b, sticky_c, sticky_d;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // Defaults: WIDTH=16, NREGS=8, BYPASS=1, ZERO_R0=0
   rf_bypass_param u_a (
      .clk(clk), .rst_n(rst_n), .readReg1Sel(sel1), .readReg2Sel(sel2),
      .writeRegSel(wsel), .writeData(wd[15:0]), .writeEn(we_a), .errClr(err_clr),
      .readData1(rd1_a), .readData2(rd2_a), .err(err_a), .errSticky(sticky_a));

   // No bypass
   rf_bypass_param #(.BYPASS(0)) u_b (
      .clk(clk), .rst_n(rst_n), .readReg1Sel(sel1), .readReg2Sel(sel2),
      .writeRegSel(wsel), .writeData(wd[15:0]), .writeEn(we_b), .errClr(err_clr),
      .readData1(rd1_b), .readData2(rd2_b), .err(err_b), .errSticky(sticky_b));

   // Hardwired-zero r0, 32-bit
   rf_bypass_param #(.WIDTH(32), .ZERO_R0(1)) u_c (
      .clk(clk), .rst_n(rst_n), .readReg1Sel(sel1), .readReg2Sel(sel2),
      .writeRegSel(wsel), .writeData(wd), .writeEn(we_c), .errClr(err_clr),
      .readData1(rd1_c), .readData2(rd2_c), .err(err_c), .errSticky(sticky_c));

   // Six registers: codes 6 and 7 are out of range
   rf_bypass_param #(.NREGS(6)) u_d (
      .clk(clk), .rst_n(rst_n), .readReg1Sel(sel1), .readReg2Sel(sel2),
      .writeRegSel(wsel), .writeData(wd[15:0]), .writeEn(we_d), .errClr(err_clr),
      .readData1(rd1_d), .readData2(rd2_d), .err(err_d), .errSticky(sticky_d));

   task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; sel1 = '0; sel2 = '0; wsel = '0; wd = '0;
      we_a = 1'b0; we_b = 1'b0; we_c = 1'b0; we_d = 1'b0; err_clr = 1'b0;

      // Reset state, including a write attempt that must not bypass or land
      #2;
      chk_w("rst_rd1", 32'(rd1_a), 32'h0);
      chk_b("rst_err", err_a, 1'b0);
      chk_b("rst_sticky", sticky_d, 1'b0);
      we_a = 1'b1; wsel = 3'd1; wd = 32'h1234; sel1 = 3'd1;
      #1;
      chk_w("rst_no_bypass", 32'(rd1_a), 32'h0);
      tick;                                   // edge while in reset
      we_a = 1'b0;
      #1;
      chk_w("rst_no_write", 32'(rd1_a), 32'h0);
      rst_n = 1'b1;
      tick;

      // 1. basic write then read
      we_a = 1'b1; wsel = 3'd3; wd = 32'hBEEF; tick;
      wsel = 3'd5; wd = 32'h1234; tick;
      we_a = 1'b0; sel1 = 3'd3; sel2 = 3'd5; #1;
      chk_w("t1_rd1", 32'(rd1_a), 32'hBEEF);
      chk_w("t1_rd2", 32'(rd2_a), 32'h1234);
      chk_b("t1_err", err_a, 1'b0);

      // 2. bypass vs. no bypass
      we_a = 1'b1; we_b = 1'b1; wsel = 3'd2; wd = 32'h0001; tick;
      wd = 32'hA5A5; sel1 = 3'd2; sel2 = 3'd2; #1;
      chk_w("t2_byp_rd1", 32'(rd1_a), 32'hA5A5);
      chk_w("t2_byp_rd2", 32'(rd2_a), 32'hA5A5);
      chk_w("t2_nobyp_rd1", 32'(rd1_b), 32'h0001);
      chk_w("t2_nobyp_rd2", 32'(rd2_b), 32'h0001);
      tick;
      we_a = 1'b0; we_b = 1'b0; wd = 32'hFFFF; #1;
      chk_w("t2_nobyp_after1", 32'(rd1_b), 32'hA5A5);
      chk_w("t2_nobyp_after2", 32'(rd2_b), 32'hA5A5);
      chk_w("t2_we0_no_byp", 32'(rd1_a), 32'hA5A5);

      // 3. hardwired-zero r0, 32-bit
      we_c = 1'b1; wsel = 3'd0; wd = 32'hFFFFFFFF; sel1 = 3'd0; #1;
      chk_w("t3_r0_no_byp", rd1_c, 32'h0);
      chk_b("t3_err", err_c, 1'b0);
      tick;
      we_c = 1'b0; #1;
      chk_w("t3_r0_zero", rd1_c, 32'h0);
      we_c = 1'b1; wsel = 3'd1; wd = 32'hDEADBEEF; sel1 = 3'd1; #1;
      chk_w("t3_r1_byp", rd1_c, 32'hDEADBEEF);
      tick;
      we_c = 1'b0; #1;
      chk_w("t3_r1_stored", rd1_c, 32'hDEADBEEF);

      // 4. NREGS=6 range errors and sticky flag
      chk_b("t4_sticky_init", sticky_d, 1'b0);
      we_d = 1'b1; wsel = 3'd5; wd = 32'h00AA; tick;
      wsel = 3'd7; wd = 32'hFFFF; sel1 = 3'd5; #1;
      chk_b("t4_wr_err", err_d, 1'b1);
      chk_w("t4_oor_no_byp", 32'(rd1_d), 32'h00AA);
      tick;
      we_d = 1'b0; #1;
      chk_b("t4_sticky_set", sticky_d, 1'b1);
      chk_b("t4_err_clear", err_d, 1'b0);
      chk_w("t4_r5_kept", 32'(rd1_d), 32'h00AA);
      sel2 = 3'd6; #1;
      chk_w("t4_rd2_oor", 32'(rd2_d), 32'h0);
      chk_b("t4_rd_err", err_d, 1'b1);
      chk_b("t4_pow2_no_err", err_a, 1'b0);
      tick;
      sel2 = 3'd2; err_clr = 1'b1; #1;
      chk_b("t4_legal_err", err_d, 1'b0);
      tick;
      chk_b("t4_sticky_cleared", sticky_d, 1'b0);
      err_clr = 1'b0; sel2 = 3'd6; tick;
      chk_b("t4_sticky_reset", sticky_d, 1'b1);
      err_clr = 1'b1; tick;
      chk_b("t4_set_wins", sticky_d, 1'b1);
      sel2 = 3'd2; tick;
      chk_b("t4_sticky_clr2", sticky_d, 1'b0);
      err_clr = 1'b0;

      // 5. async reset mid-cycle
      we_a = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wsel = 3'(i); wd = 32'(16'h1111 * i); tick;
      end
      we_a = 1'b0;
      sel2 = 3'd6; tick;                      // set D sticky before reset
      sel1 = 3'd7; sel2 = 3'd3; #1;
      chk_w("t5_fill_r7", 32'(rd1_a), 32'h7777);
      chk_w("t5_fill_r3", 32'(rd2_a), 32'h3333);
      chk_b("t5_sticky_pre", sticky_d, 1'b1);
      #2;
      rst_n = 1'b0; #1;
      chk_w("t5_rst_rd1", 32'(rd1_a), 32'h0);
      chk_w("t5_rst_rd2", 32'(rd2_a), 32'h0);
      chk_b("t5_rst_sticky", sticky_d, 1'b0);
      #1;
      rst_n = 1'b1; we_a = 1'b1; wsel = 3'd4; wd = 32'h4444;
      tick;
      we_a = 1'b0; sel1 = 3'd4; sel2 = 3'd7; #1;
      chk_w("t5_first_write", 32'(rd1_a), 32'h4444);
      chk_w("t5_others_zero", 32'(rd2_a), 32'h0);

      // 6. back-to-back writes to r4 with bypass
      we_a = 1'b1; wsel = 3'd4; sel1 = 3'd4;
      wd = 32'h0010; #1;
      chk_w("t6_w0", 32'(rd1_a), 32'h0010);
      tick;
      wd = 32'h0020; #1;
      chk_w("t6_w1", 32'(rd1_a), 32'h0020);
      tick;
      wd = 32'h0030; #1;
      chk_w("t6_w2", 32'(rd1_a), 32'h0030);
      tick;
      we_a = 1'b0; wd = 32'h0; #1;
      chk_w("t6_final", 32'(rd1_a), 32'h0030);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
